// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: access size codes,
// the controller state encoding and the default memory depth.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  localparam int MEM_WORDS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo[1:0];
      default:   bad = |addr_lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering: extracts and extends the addressed lane of a memory
// word for loads, and merges store data into the addressed lane(s) for
// read-modify-write stores. Little-endian lane order.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int dataWidth = 64
) (
  input  logic [dataWidth-1:0] word,
  input  logic [dataWidth-1:0] store_data,
  input  logic [1:0]           size,
  input  logic                 is_signed,
  input  logic [2:0]           offset,
  output logic [dataWidth-1:0] load_data,
  output logic [dataWidth-1:0] merged_word
);

  logic [5:0]           shamt;
  logic [dataWidth-1:0] shifted;
  logic [dataWidth-1:0] lane_mask;
  logic [dataWidth-1:0] lane_mask_sh;

  // Shift the addressed lane down to bit 0, extend it, and build the merge mask.
  always_comb begin
    shamt        = {offset, 3'b000};
    shifted      = word >> shamt;
    lane_mask    = '1;
    load_data    = word;
    case (size)
      SIZE_BYTE: begin
        lane_mask = dataWidth'(8'hFF);
        load_data = {{(dataWidth-8){is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        lane_mask = dataWidth'(16'hFFFF);
        load_data = {{(dataWidth-16){is_signed & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        lane_mask = dataWidth'(32'hFFFF_FFFF);
        load_data = {{(dataWidth-32){is_signed & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        lane_mask = '1;
        load_data = word;
      end
    endcase
    lane_mask_sh = lane_mask << shamt;
    merged_word  = (word & ~lane_mask_sh) | ((store_data << shamt) & lane_mask_sh);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store unit in front of a word-addressed memory.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; valid must not depend on ready, and the payload is held stable by
// its source until that edge. Sub-word stores are read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int dataWidth    = 64,
  parameter int addressWidth = 64,
  parameter int memWords     = MEM_WORDS_DEFAULT,
  parameter int WAIT_CYCLES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addressWidth-1:0] req_address,
  input  logic [dataWidth-1:0]    req_write_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [dataWidth-1:0]    resp_read_data,
  output logic                    resp_error,
  output logic [addressWidth-1:0] mem_address,
  output logic [dataWidth-1:0]    mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [dataWidth-1:0]    mem_read_data
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_last;
  logic                 req_err;
  logic                 store_q;
  logic                 signed_q;
  logic [1:0]           size_q;
  logic [2:0]           offset_q;
  logic [dataWidth-1:0] wdata_q;
  logic [dataWidth-1:0] load_data;
  logic [dataWidth-1:0] merged_word;

  assign cnt_last = (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign req_err  = is_misaligned(req_size, req_address[2:0]) ||
                    ((req_address >> 3) >= addressWidth'(memWords));

  mem_lane_align #(.dataWidth(dataWidth)) u_lane (
    .word        (mem_read_data),
    .store_data  (wdata_q),
    .size        (size_q),
    .is_signed   (signed_q),
    .offset      (offset_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and strobe/handshake decode.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                               next_state = RESP;
          else if (req_store && req_size == SIZE_DOUBLE) next_state = WRITE;
          else                                       next_state = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        if (cnt_last) next_state = store_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        if (cnt_last) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobe-length counter; restarts at each READ/WRITE phase boundary.
  always_ff @(posedge clock) begin
    if (reset)                                              cnt <= '0;
    else if ((state == READ || state == WRITE) && !cnt_last) cnt <= cnt + 1'b1;
    else                                                    cnt <= '0;
  end

  // Request latch, memory address/data registers and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      store_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= SIZE_BYTE;
      offset_q       <= 3'd0;
      wdata_q        <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_read_data <= '0;
      resp_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q        <= req_store;
            signed_q       <= req_signed;
            size_q         <= req_size;
            offset_q       <= req_address[2:0];
            wdata_q        <= req_write_data;
            resp_error     <= req_err;
            resp_read_data <= '0;
            if (!req_err) begin
              mem_address    <= req_address >> 3;
              // Final for double stores; replaced by the merged word otherwise.
              mem_write_data <= req_write_data;
            end
          end
        end
        READ: begin
          if (cnt_last) begin
            if (store_q) mem_write_data <= merged_word;
            else         resp_read_data <= load_data;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_error     <= 1'b0;
            resp_read_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic
// against a byte-array reference model and a 2-cycle word memory.
module tb_mem_access_unit;

  localparam int DW        = 64;
  localparam int AW        = 64;
  localparam int MEM_WORDS = 64;
  localparam int WAIT      = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req_valid, req_ready, req_store, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_write_data;
  logic          resp_valid, resp_ready, resp_error;
  logic [DW-1:0] resp_read_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write, mem_read;

  mem_access_unit #(
    .dataWidth(DW), .addressWidth(AW), .memWords(MEM_WORDS), .WAIT_CYCLES(WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
    .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_read_data(resp_read_data), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) * 32'h9E37_79B9, (32'(i) * 32'h85EB_CA6B) ^ 32'hA5A5_5A5A};
  endfunction

  // ---------------- memory model (2-cycle read/write) ----------------
  logic        mem_init;
  logic [63:0] mem [0:MEM_WORDS-1];
  int          wr_run;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
      wr_run        <= 0;
      mem_read_data <= '0;
    end else begin
      if (mem_read) mem_read_data <= mem[mem_address[5:0]];
      else          mem_read_data <= 64'hDEAD_BEEF_DEAD_BEEF;
      if (mem_write && !reset) begin
        if (wr_run == WAIT - 1) begin
          mem[mem_address[5:0]] <= mem_write_data;
          wr_run <= 0;
        end else begin
          wr_run <= wr_run + 1;
        end
      end else begin
        wr_run <= 0;
      end
    end
  end

  // ---------------- strobe monitor ----------------
  int          rd_total = 0, wr_total = 0, excl_viol = 0, stab_viol = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [63:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clock) begin
    if (mem_read === 1'b1)  rd_total++;
    if (mem_write === 1'b1) wr_total++;
    if (mem_read === 1'b1 && mem_write === 1'b1) excl_viol++;
    if ((prev_rd || prev_wr) && (mem_read === 1'b1 || mem_write === 1'b1) && mem_address !== prev_addr)
      stab_viol++;
    if (prev_wr && mem_write === 1'b1 && mem_write_data !== prev_wdata) stab_viol++;
    prev_rd    = (mem_read === 1'b1);
    prev_wr    = (mem_write === 1'b1);
    prev_addr  = mem_address;
    prev_wdata = mem_write_data;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:MEM_WORDS*8-1];
  logic [63:0] exp_q [$];

  function automatic logic ref_err(input logic [1:0] sz, input logic [63:0] addr);
    int n = 1 << sz;
    return ((addr & 64'(n - 1)) != 64'd0) || ((addr >> 3) >= 64'(MEM_WORDS));
  endfunction

  function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic sg, input logic [63:0] addr);
    int n = 1 << sz;
    int base = int'(addr);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
    if (sg && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd);
    int n = 1 << sz;
    int base = int'(addr);
    for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8 * i +: 8];
  endtask

  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] v = '0;
    for (int b = 0; b < 8; b++) v = v | (64'(ref_mem[w * 8 + b]) << (8 * b));
    return v;
  endfunction

  // ---------------- checking ----------------
  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input int bp, input string tag, output logic [63:0] got);
    int lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
    logic e;
    logic [63:0] exp_d;
    e       = ref_err(sz, addr);
    exp_d   = (e || st) ? 64'd0 : ref_load(sz, sg, addr);
    exp_lat = e ? 1 : ((st && sz != 2'b11) ? 2 * WAIT + 1 : WAIT + 1);
    exp_rd  = e ? 0 : ((!st || sz != 2'b11) ? WAIT : 0);
    exp_wr  = (e || !st) ? 0 : WAIT;
    exp_q.push_back(exp_d);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    rd0 = rd_total;
    wr0 = wr_total;
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_address = addr; req_write_data = wd;
    tick();
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      req_valid      = 1'($urandom_range(0, 1));
      req_store      = 1'($urandom_range(0, 1));
      req_size       = 2'($urandom_range(0, 3));
      req_address    = {$urandom(), $urandom()};
      req_write_data = {$urandom(), $urandom()};
      tick();
      lat++;
    end
    got = resp_read_data;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(resp_error), 64'(e));
    check({tag, "_data"}, resp_read_data, exp_q.pop_front());
    for (int k = 0; k < bp; k++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_data"}, resp_read_data, exp_d);
      check({tag, "_hold_err"}, 64'(resp_error), 64'(e));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, "_release"}, 64'(resp_valid), 64'd0);
    check({tag, "_idle"}, 64'(req_ready), 64'd1);
    check({tag, "_rd_cycles"}, 64'(rd_total - rd0), 64'(exp_rd));
    check({tag, "_wr_cycles"}, 64'(wr_total - wr0), 64'(exp_wr));
    if (!e && st) ref_store(sz, addr, wd);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] got, addr, wd, old;
    logic        st, sg;
    logic [1:0]  sz;
    int          n;

    for (int w = 0; w < MEM_WORDS; w++)
      for (int b = 0; b < 8; b++) ref_mem[w * 8 + b] = init_word(w)[8 * b +: 8];

    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_address = '0; req_write_data = '0; resp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0; mem_init = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_resp_data", resp_read_data, 64'd0);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);

    // Double store then load.
    do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 0, "dstore", got);
    do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 0, "dload", got);
    check("dload_const", got, 64'h1122_3344_5566_7788);

    // Byte store by read-modify-write.
    do_req(1'b1, 2'b00, 1'b0, 64'h13, 64'hAB, 0, "bstore", got);
    check("bstore_mem", mem[2], 64'h1122_3344_AB66_7788);
    do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 0, "bload", got);
    check("bload_const", got, 64'h1122_3344_AB66_7788);

    // Signed versus unsigned half load, with backpressure on the first.
    do_req(1'b1, 2'b01, 1'b0, 64'h18, 64'h8001, 0, "hstore", got);
    do_req(1'b0, 2'b01, 1'b1, 64'h18, 64'd0, 4, "hload_s", got);
    check("hload_s_const", got, 64'hFFFF_FFFF_FFFF_8001);
    do_req(1'b0, 2'b01, 1'b0, 64'h18, 64'd0, 0, "hload_u", got);
    check("hload_u_const", got, 64'h0000_0000_0000_8001);

    // Error cases.
    do_req(1'b0, 2'b10, 1'b0, 64'h0E, 64'd0, 0, "err_misalign", got);
    do_req(1'b0, 2'b11, 1'b0, 64'h200, 64'd0, 0, "err_range", got);

    // Reset in the second WRITE cycle of a double store.
    old = ref_word(5);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b11; req_signed = 1'b0;
    req_address = 64'h28; req_write_data = 64'hCAFE_F00D_1234_5678;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (mem_write !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("abort_wr_cycle1", 64'(mem_write), 64'd1);
    tick();
    check("abort_wr_cycle2", 64'(mem_write), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_resp_error", 64'(resp_error), 64'd0);
    check("abort_resp_data", resp_read_data, 64'd0);
    check("abort_mem_read", 64'(mem_read), 64'd0);
    check("abort_mem_write", 64'(mem_write), 64'd0);
    check("abort_mem_address", mem_address, 64'd0);
    check("abort_mem_wdata", mem_write_data, 64'd0);
    check("abort_mem_word", mem[5], old);
    do_req(1'b0, 2'b11, 1'b0, 64'h28, 64'd0, 0, "abort_reload", got);
    check("abort_reload_const", got, old);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      st   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      addr = 64'($urandom_range(0, MEM_WORDS * 8 + 63));
      if ($urandom_range(0, 9) < 7) addr = addr & ~64'((1 << sz) - 1);
      wd   = {$urandom(), $urandom()};
      do_req(st, sz, sg, addr, wd, int'($urandom_range(0, 3)), "rnd", got);
    end

    for (int w = 0; w < MEM_WORDS; w++) check("mem_final", mem[w], ref_word(w));
    check("strobe_exclusive", 64'(excl_viol), 64'd0);
    check("strobe_stable", 64'(stab_viol), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
